arranque_rampa_pwm: RTL and testbench
=====================================

Name: arranque_rampa_pwm

Overview:
Parametrised soft-start motor driver with PWM output. It replaces fixed 30/50/100 % level outputs with a duty register that ramps up and down in configurable steps. Fast or slow dwell per step is selected by rapido/lento. The block adds ramp-down on stop, re-acceleration from mid-ramp, an emergency-stop fault state, and status flags. It sits between the operator command logic and the motor power-stage gate driver.

Parameters:
PWM_W, 8, duty/PWM counter width; DMAX = 2^PWM_W-1
DUTY_MIN, 77, first duty on start (~30 %); must be 1..DMAX
DUTY_STEP, 64, duty increment/decrement per step; must be >=1
DWELL_FAST, 4, clk cycles per step in fast mode; must be >=1
DWELL_SLOW, 16, clk cycles per step in slow mode; must be >=1
DWELL_W, 16, dwell counter width; must hold DWELL_SLOW

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  level run request: 1 = run, 0 = stop with ramp-down
rapido  in  1  fast-ramp select; has priority over lento
lento  in  1  slow-ramp select
estop  in  1  emergency stop, level-sensitive
pwm_out  out  1  registered PWM gate drive
duty  out  PWM_W  current duty register
state  out  3  FSM state: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, FAULT=4
at_speed  out  1  high only in RUN
busy  out  1  high in RAMP_UP or RAMP_DOWN

Behaviour:
- Reset, asynchronous: state=IDLE, duty=0, dwell counter=0, PWM counter=0, pwm_out=0, mode=slow, at_speed=0, busy=0.
- Mode latching: mode is latched on the IDLE->RAMP_UP edge: rapido=1 -> fast, otherwise slow. This includes rapido=lento=0. Mode is held until the next IDLE exit. dwell = DWELL_FAST if fast, else DWELL_SLOW.
- Dwell counter: counts 0..dwell-1 in RAMP_UP/RAMP_DOWN. Its terminal count is a step event. It clears on every state change.
- estop has priority over all other transitions in every state.
  - estop=1 -> FAULT at the next edge, with duty=0 and pwm_out=0 at that same edge.
- IDLE:
  - duty=0.
  - start=1 & estop=0 -> RAMP_UP, with duty<=DUTY_MIN.
- RAMP_UP, on step event:
  - sum is computed in PWM_W+1 bits: duty<=min(duty+DUTY_STEP, DMAX).
  - If the result == DMAX -> RUN on the same edge.
  - start=0 -> RAMP_DOWN; duty is held and the counter cleared.
- RUN:
  - duty=DMAX.
  - start=0 -> RAMP_DOWN.
- RAMP_DOWN, on step event:
  - If duty < DUTY_MIN+DUTY_STEP (compared in PWM_W+1 bits): duty<=0 and -> IDLE.
  - Otherwise duty<=duty-DUTY_STEP.
  - start=1 -> RAMP_UP from the current duty, with no reset to DUTY_MIN and the mode not re-latched.
- FAULT:
  - duty=0.
  - Exit only when estop=0 and start=0 -> IDLE.
  - start held high while in FAULT keeps the block in FAULT, so there is no auto-restart.
- PWM generation:
  - The PWM counter is free-running, 0..DMAX, and wraps to 0.
  - pwm_out<=(duty==DMAX) ? 1 : (pwm_cnt < duty). This gives one cycle of latency after duty and is forced 0 whenever the next state is FAULT or IDLE.
  - duty=0 -> constant 0; duty=DMAX -> constant 1.
- Simultaneous events:
  - Step event and start falling in RAMP_UP: the step is not applied; go to RAMP_DOWN.
  - Step event and start rising in RAMP_DOWN: the step is not applied; go to RAMP_UP.
- Status flags: at_speed and busy are registered and decoded from the next state, so they align with state.
- Reset mid-ramp: immediate return to the reset values.

Test Plan:
1. Fast ramp-up (defaults): reset, rapido=1, start=1 -> duty 77 in RAMP_UP, then 141 four cycles later, 205 after eight, 255 and RUN after twelve; at_speed=1 and pwm_out constant 1.
2. Slow ramp and ramp-down: lento=1, start=1 until RUN (48 cycles after entry), then start=0 -> duty 191, 127 at 16-cycle intervals, then duty 0 and IDLE on the third step; pwm_out=0 in IDLE.
3. PWM duty check: force the RAMP_UP hold with DWELL_SLOW at duty 77 and count pwm_out highs over one 256-cycle period -> exactly 77.
4. Reversal: fast ramp at duty 141, drop start for one step event -> duty 77? No: 141<141 is false -> 77. Then raise start -> RAMP_UP continues 141, 205, 255 with fast dwell retained.
5. E-stop: assert estop during RUN -> next edge state=4, duty=0, pwm_out=0. Holding start=1 with estop released keeps FAULT; start=0 -> IDLE.
6. Async reset mid-ramp at duty 205 -> duty, pwm_out, state, at_speed and busy all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arranque_rampa_pwm.sv
`default_nettype none
// ============================================================================
// Module      : arranque_rampa_pwm
// Description : Soft-start motor driver. A duty register ramps up from
//               DUTY_MIN to full scale in DUTY_STEP increments (and back down
//               on stop), with a fast/slow dwell per step latched at start.
//               The duty drives a free-running PWM comparator whose
//               registered output feeds the power-stage gate driver.
//               estop forces a latched FAULT state with the output off.
// Ports       : clk, reset (async, active-high)
//               start   - run request level (0 = stop with ramp-down)
//               rapido  - fast-ramp select (wins over lento)
//               lento   - slow-ramp select
//               estop   - emergency stop, level-sensitive
//               pwm_out - registered PWM gate drive
//               duty    - current duty register
//               state   - IDLE=0 RAMP_UP=1 RUN=2 RAMP_DOWN=3 FAULT=4
//               at_speed- high in RUN
//               busy    - high in RAMP_UP / RAMP_DOWN
// Revision    : 1.0 - initial release
// ============================================================================
module arranque_rampa_pwm #(
  parameter int PWM_W      = 8,
  parameter int DUTY_MIN   = 77,
  parameter int DUTY_STEP  = 64,
  parameter int DWELL_FAST = 4,
  parameter int DWELL_SLOW = 16,
  parameter int DWELL_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rapido,
  input  logic             lento,
  input  logic             estop,
  output logic             pwm_out,
  output logic [PWM_W-1:0] duty,
  output logic [2:0]       state,
  output logic             at_speed,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [PWM_W-1:0]   DMAX      = '1;
  localparam logic [PWM_W:0]     DMAX_X    = {1'b0, DMAX};
  localparam logic [PWM_W-1:0]   MIN_D     = PWM_W'(DUTY_MIN);
  localparam logic [PWM_W:0]     STEP_X    = (PWM_W+1)'(DUTY_STEP);
  // Ramp-down floor: below this, one more step would undershoot DUTY_MIN.
  localparam logic [PWM_W:0]     DOWN_LIM  = (PWM_W+1)'(DUTY_MIN + DUTY_STEP);
  localparam logic [DWELL_W-1:0] DW_FAST   = DWELL_W'(DWELL_FAST);
  localparam logic [DWELL_W-1:0] DW_SLOW   = DWELL_W'(DWELL_SLOW);

  state_t             cur_st, nxt_st;
  logic [PWM_W-1:0]   duty_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt, dwell_sel;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               fast_mode, fast_nxt;
  logic               step;
  logic               pwm_nxt;
  logic [PWM_W:0]     sum_up;

  assign dwell_sel = fast_mode ? DW_FAST : DW_SLOW;
  assign step      = (dwell_cnt == dwell_sel - 1'b1);
  assign sum_up    = {1'b0, duty} + STEP_X;
  assign state     = cur_st;

  // Next-state, next-duty, dwell and mode logic
  always_comb begin
    nxt_st   = cur_st;
    duty_nxt = duty;
    fast_nxt = fast_mode;

    unique case (cur_st)
      IDLE: begin
        duty_nxt = '0;
        if (start) begin
          nxt_st   = RAMP_UP;
          duty_nxt = MIN_D;
          fast_nxt = rapido;
        end
      end
      RAMP_UP: begin
        // A falling start wins over a coincident step: duty is held.
        if (!start) begin
          nxt_st = RAMP_DOWN;
        end else if (step) begin
          if (sum_up >= DMAX_X) begin
            duty_nxt = DMAX;
            nxt_st   = RUN;
          end else begin
            duty_nxt = sum_up[PWM_W-1:0];
          end
        end
      end
      RUN: begin
        duty_nxt = DMAX;
        if (!start) nxt_st = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        // Re-acceleration resumes from the current duty, mode unchanged.
        if (start) begin
          nxt_st = RAMP_UP;
        end else if (step) begin
          if ({1'b0, duty} < DOWN_LIM) begin
            duty_nxt = '0;
            nxt_st   = IDLE;
          end else begin
            duty_nxt = duty - STEP_X[PWM_W-1:0];
          end
        end
      end
      FAULT: begin
        duty_nxt = '0;
        if (!start) nxt_st = IDLE;
      end
      default: begin
        nxt_st   = IDLE;
        duty_nxt = '0;
      end
    endcase

    if (estop) begin
      nxt_st   = FAULT;
      duty_nxt = '0;
    end

    dwell_nxt = '0;
    if (nxt_st == cur_st && (cur_st == RAMP_UP || cur_st == RAMP_DOWN) && !step)
      dwell_nxt = dwell_cnt + 1'b1;

    // Full scale is a constant high; IDLE/FAULT entry silences the output.
    if (nxt_st == FAULT || nxt_st == IDLE)
      pwm_nxt = 1'b0;
    else if (duty == DMAX)
      pwm_nxt = 1'b1;
    else
      pwm_nxt = (pwm_cnt < duty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st    <= IDLE;
      duty      <= '0;
      dwell_cnt <= '0;
      pwm_cnt   <= '0;
      pwm_out   <= 1'b0;
      fast_mode <= 1'b0;
      at_speed  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      duty      <= duty_nxt;
      dwell_cnt <= dwell_nxt;
      pwm_cnt   <= pwm_cnt + 1'b1;
      pwm_out   <= pwm_nxt;
      fast_mode <= fast_nxt;
      at_speed  <= (nxt_st == RUN);
      busy      <= (nxt_st == RAMP_UP) || (nxt_st == RAMP_DOWN);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arranque_rampa_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_arranque_rampa_pwm
// Description : Directed self-checking bench for arranque_rampa_pwm. A second
//               instance with a long slow dwell holds duty at DUTY_MIN long
//               enough to measure one full PWM period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arranque_rampa_pwm;

  logic       clk = 1'b0;
  logic       reset, start, rapido, lento, estop;
  logic       pwm_out, at_speed, busy;
  logic [7:0] duty;
  logic [2:0] state;

  logic       reset2, start2, rapido2, lento2, estop2;
  logic       pwm_out2, at_speed2, busy2;
  logic [7:0] duty2;
  logic [2:0] state2;

  int n_chk  = 0;
  int n_fail = 0;
  int highs;

  always #5 clk = ~clk;

  arranque_rampa_pwm u_dut (
    .clk(clk), .reset(reset), .start(start), .rapido(rapido), .lento(lento),
    .estop(estop), .pwm_out(pwm_out), .duty(duty), .state(state),
    .at_speed(at_speed), .busy(busy)
  );

  arranque_rampa_pwm #(.DWELL_SLOW(400)) u_dut_pwm (
    .clk(clk), .reset(reset2), .start(start2), .rapido(rapido2), .lento(lento2),
    .estop(estop2), .pwm_out(pwm_out2), .duty(duty2), .state(state2),
    .at_speed(at_speed2), .busy(busy2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rapido = 1'b0; lento = 1'b0; estop = 1'b0;
    reset2 = 1'b1; start2 = 1'b0; rapido2 = 1'b0; lento2 = 1'b1; estop2 = 1'b0;
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_duty", duty, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_at_speed", at_speed, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick(2);
    chk("idle_hold", state, 0);

    // Fast ramp-up
    rapido = 1'b1; start = 1'b1;
    tick(1);
    chk("up_entry_state", state, 1);
    chk("up_entry_duty", duty, 77);
    chk("up_entry_busy", busy, 1);
    tick(3);
    chk("up_dwell_hold", duty, 77);
    tick(1);
    chk("up_step1", duty, 141);
    tick(4);
    chk("up_step2", duty, 205);
    tick(4);
    chk("up_run_duty", duty, 255);
    chk("up_run_state", state, 2);
    chk("up_at_speed", at_speed, 1);
    chk("up_busy_off", busy, 0);
    tick(1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      highs += int'(pwm_out);
      tick(1);
    end
    chk("run_pwm_const", highs, 10);

    // Fast ramp-down to IDLE
    start = 1'b0;
    tick(1);
    chk("dn_entry_state", state, 3);
    chk("dn_entry_duty", duty, 255);
    tick(12);
    chk("dn_fast_idle", state, 0);
    chk("dn_fast_duty", duty, 0);

    // Slow ramp (lento) up to RUN then down
    rapido = 1'b0; lento = 1'b1; start = 1'b1;
    tick(1);
    chk("slow_entry", duty, 77);
    tick(16);
    chk("slow_step1", duty, 141);
    tick(16);
    chk("slow_step2", duty, 205);
    tick(15);
    chk("slow_pre_run", state, 1);
    tick(1);
    chk("slow_run_state", state, 2);
    chk("slow_run_duty", duty, 255);
    start = 1'b0;
    tick(1);
    chk("sdn_entry", state, 3);
    tick(16);
    chk("sdn_step1", duty, 191);
    tick(16);
    chk("sdn_step2", duty, 127);
    tick(15);
    chk("sdn_hold", duty, 127);
    tick(1);
    chk("sdn_idle_state", state, 0);
    chk("sdn_idle_duty", duty, 0);
    chk("sdn_idle_pwm", pwm_out, 0);
    chk("sdn_idle_busy", busy, 0);

    // Reversal mid-ramp, fast mode retained
    lento = 1'b0; rapido = 1'b1; start = 1'b1;
    tick(5);
    chk("rev_at_141", duty, 141);
    start = 1'b0;
    tick(1);
    chk("rev_down_state", state, 3);
    chk("rev_down_hold", duty, 141);
    tick(4);
    chk("rev_down_step", duty, 77);
    start = 1'b1; rapido = 1'b0;
    tick(1);
    chk("rev_up_state", state, 1);
    chk("rev_up_duty", duty, 77);
    tick(4);
    chk("rev_up_141", duty, 141);
    tick(4);
    chk("rev_up_205", duty, 205);
    tick(4);
    chk("rev_up_run", state, 2);

    // Emergency stop from RUN
    tick(2);
    chk("pre_estop_pwm", pwm_out, 1);
    estop = 1'b1;
    tick(1);
    chk("estop_state", state, 4);
    chk("estop_duty", duty, 0);
    chk("estop_pwm", pwm_out, 0);
    chk("estop_at_speed", at_speed, 0);
    estop = 1'b0;
    tick(3);
    chk("fault_latched", state, 4);
    start = 1'b0;
    tick(1);
    chk("fault_exit", state, 0);

    // Async reset mid-ramp
    rapido = 1'b1; start = 1'b1;
    tick(9);
    chk("pre_rst_duty", duty, 205);
    #2 reset = 1'b1;
    #1;
    chk("arst_duty", duty, 0);
    chk("arst_state", state, 0);
    chk("arst_pwm", pwm_out, 0);
    chk("arst_at_speed", at_speed, 0);
    chk("arst_busy", busy, 0);
    start = 1'b0;
    tick(1);
    reset = 1'b0;

    // PWM duty measurement at DUTY_MIN
    reset2 = 1'b0;
    tick(1);
    start2 = 1'b1;
    tick(1);
    chk("pwm_entry_state", state2, 1);
    chk("pwm_entry_duty", duty2, 77);
    tick(1);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      highs += int'(pwm_out2);
      tick(1);
    end
    chk("pwm_highs_77", highs, 77);
    chk("pwm_duty_held", duty2, 77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
